// File: rtl/dmem_arbiter.sv
// Purpose: shares the single data-memory port between the CPU MEM stage and a debug/loader port.
// Latency: memory access is combinational for the granted side; debug response appears 1 cycle after accept.
// Backpressure: CPU is stalled only on a debug grant; debug waits on DbgReady and holds its response until DbgRspReady.
//
// Ports:
//   CLK, RST_N                     clock (rising edge), asynchronous active-low reset
//   Cpu{Req,Write,Addr,WD,Type}    MEM-stage access request; CpuRD load data, CpuStall hold request
//   Dbg{Valid,Write,Addr,WD,Type}  debug request channel, DbgReady = accepted this cycle
//   DbgRsp{Valid,Ready,Data}       debug response channel (write acks return 0)
//   Mem{Addr,WD,Type,Write}, MemRD Memorytop port (combinational read, write on clock edge)
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CpuReq,
    input  logic        CpuWrite,
    input  logic [31:0] CpuAddr,
    input  logic [31:0] CpuWD,
    input  logic [2:0]  CpuType,
    output logic [31:0] CpuRD,
    output logic        CpuStall,
    input  logic        DbgValid,
    output logic        DbgReady,
    input  logic        DbgWrite,
    input  logic [31:0] DbgAddr,
    input  logic [31:0] DbgWD,
    input  logic [2:0]  DbgType,
    output logic        DbgRspValid,
    input  logic        DbgRspReady,
    output logic [31:0] DbgRspData,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWD,
    output logic [2:0]  MemType,
    output logic        MemWrite,
    input  logic [31:0] MemRD
);

    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              rsp_vld_nxt;
    logic [31:0]       rsp_dat_nxt;
    logic              wait_full;
    logic              dbg_gnt;
    logic              cpu_gnt;

    // With MAX_WAIT=0 the counter sits at 0, which equals the limit, so debug always wins.
    assign wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));

    // Grant and memory mux. Gating with RST_N keeps writes, grants and stalls off while in reset.
    always_comb begin
        dbg_gnt  = RST_N && (state == IDLE) && DbgValid && (!CpuReq || wait_full);
        cpu_gnt  = CpuReq && !dbg_gnt;
        DbgReady = dbg_gnt;
        CpuStall = RST_N && CpuReq && !cpu_gnt;
        CpuRD    = MemRD;
        MemAddr  = dbg_gnt ? DbgAddr : CpuAddr;
        MemWD    = dbg_gnt ? DbgWD   : CpuWD;
        MemType  = dbg_gnt ? DbgType : CpuType;
        MemWrite = RST_N && ((dbg_gnt && DbgWrite) || (cpu_gnt && CpuWrite));
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rsp_vld_nxt  = DbgRspValid;
        rsp_dat_nxt  = DbgRspData;
        case (state)
            IDLE: begin
                if (dbg_gnt) begin
                    state_nxt    = RSP;
                    rsp_vld_nxt  = 1'b1;
                    // Writes commit on this same edge; the ack carries no data.
                    rsp_dat_nxt  = DbgWrite ? 32'h0 : MemRD;
                    wait_cnt_nxt = '0;
                end else if (!DbgValid) begin
                    // A dropped request forfeits its accumulated wait.
                    wait_cnt_nxt = '0;
                end else if (CpuReq && !wait_full) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            RSP: begin
                if (DbgRspReady) begin
                    state_nxt   = IDLE;
                    rsp_vld_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            DbgRspValid <= 1'b0;
            DbgRspData  <= 32'h0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            DbgRspValid <= rsp_vld_nxt;
            DbgRspData  <= rsp_dat_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed bench for dmem_arbiter with a transaction-level model and a memory stand-in.
// Latency: model tracks debug responses one cycle after accept.
// Backpressure: bench exercises response hold with DbgRspReady low and CPU/debug contention.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        CLK, RST_N;
    logic        CpuReq, CpuWrite;
    logic [31:0] CpuAddr, CpuWD;
    logic [2:0]  CpuType;
    logic [31:0] CpuRD;
    logic        CpuStall;
    logic        DbgValid, DbgReady, DbgWrite;
    logic [31:0] DbgAddr, DbgWD;
    logic [2:0]  DbgType;
    logic        DbgRspValid, DbgRspReady;
    logic [31:0] DbgRspData;
    logic [31:0] MemAddr, MemWD;
    logic [2:0]  MemType;
    logic        MemWrite;
    logic [31:0] MemRD;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuWD(CpuWD),
        .CpuType(CpuType), .CpuRD(CpuRD), .CpuStall(CpuStall),
        .DbgValid(DbgValid), .DbgReady(DbgReady), .DbgWrite(DbgWrite),
        .DbgAddr(DbgAddr), .DbgWD(DbgWD), .DbgType(DbgType),
        .DbgRspValid(DbgRspValid), .DbgRspReady(DbgRspReady), .DbgRspData(DbgRspData),
        .MemAddr(MemAddr), .MemWD(MemWD), .MemType(MemType), .MemWrite(MemWrite),
        .MemRD(MemRD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memorytop stand-in: combinational read, write on the rising edge.
    logic [31:0] mem [256];
    assign MemRD = mem[MemAddr[9:2]];
    always @(posedge CLK) begin
        if (MemWrite) mem[MemAddr[9:2]] = MemWD;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: how many cycles debug has lost in a row,
    // whether a response is owed, and what memory should hold.
    int          lost = 0;
    bit          pend = 1'b0;
    logic [31:0] pdat = 32'h0;
    logic [31:0] emem [256];
    logic        g_m, g_c;

    function automatic logic exp_gnt();
        return RST_N && !pend && DbgValid && (!CpuReq || lost >= MAX_WAIT);
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend = 1'b0;
            lost = 0;
        end else begin
            g_m = exp_gnt();
            if (pend) begin
                if (DbgRspReady) pend = 1'b0;
            end else if (g_m) begin
                pend = 1'b1;
                pdat = DbgWrite ? 32'h0 : emem[DbgAddr[9:2]];
                if (DbgWrite) emem[DbgAddr[9:2]] = DbgWD;
                lost = 0;
            end else if (!DbgValid) begin
                lost = 0;
            end else if (CpuReq) begin
                lost++;
            end
            if (!g_m && CpuReq && CpuWrite) emem[CpuAddr[9:2]] = CpuWD;
        end
    end

    always @(negedge CLK) begin
        g_c = exp_gnt();
        chk("DbgReady", 32'(DbgReady), 32'(g_c));
        chk("CpuStall", 32'(CpuStall), 32'(RST_N && CpuReq && g_c));
        chk("MemWrite", 32'(MemWrite), 32'(RST_N && (g_c ? DbgWrite : (CpuReq && CpuWrite))));
        chk("MemAddr", MemAddr, g_c ? DbgAddr : CpuAddr);
        chk("MemWD", MemWD, g_c ? DbgWD : CpuWD);
        chk("MemType", 32'(MemType), 32'(g_c ? DbgType : CpuType));
        chk("DbgRspValid", 32'(DbgRspValid), 32'(pend));
        if (pend) chk("DbgRspData", DbgRspData, pdat);
        if (RST_N && CpuReq && !CpuWrite && !g_c) chk("CpuRD", CpuRD, emem[CpuAddr[9:2]]);
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        DbgRspReady = 1'b1;
        cyc();
        DbgRspReady = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 32'h0;
            emem[i] = 32'h0;
        end
        RST_N = 1'b0;
        // Requests during reset must produce no write, grant or stall.
        CpuReq = 1'b1; CpuWrite = 1'b1; CpuAddr = 32'h40; CpuWD = 32'hBAD0BAD0; CpuType = 3'b010;
        DbgValid = 1'b1; DbgWrite = 1'b1; DbgAddr = 32'h44; DbgWD = 32'h0BADF00D; DbgType = 3'b010;
        DbgRspReady = 1'b0;
        @(negedge CLK);
        chk("rst_MemWrite", 32'(MemWrite), 32'h0);
        chk("rst_DbgReady", 32'(DbgReady), 32'h0);
        chk("rst_CpuStall", 32'(CpuStall), 32'h0);
        chk("rst_DbgRspValid", 32'(DbgRspValid), 32'h0);
        chk("rst_DbgRspData", DbgRspData, 32'h0);
        cyc();
        CpuReq = 1'b0; CpuWrite = 1'b0; DbgValid = 1'b0; DbgWrite = 1'b0;
        RST_N = 1'b1;
        cyc();

        // 1: CPU store then load
        CpuReq = 1'b1; CpuWrite = 1'b1; CpuAddr = 32'h100; CpuWD = 32'hDEADBEEF;
        @(negedge CLK);
        chk("t1_MemWrite", 32'(MemWrite), 32'h1);
        chk("t1_CpuStall", 32'(CpuStall), 32'h0);
        cyc();
        CpuWrite = 1'b0;
        @(negedge CLK);
        chk("t1_CpuRD", CpuRD, 32'hDEADBEEF);
        cyc();
        CpuReq = 1'b0;

        // 2: debug read, response held while not consumed
        DbgValid = 1'b1; DbgWrite = 1'b0; DbgAddr = 32'h100;
        @(negedge CLK);
        chk("t2_DbgReady", 32'(DbgReady), 32'h1);
        cyc();
        DbgValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t2_RspValid", 32'(DbgRspValid), 32'h1);
            chk("t2_RspData", DbgRspData, 32'hDEADBEEF);
            cyc();
        end
        drain();
        @(negedge CLK);
        chk("t2_RspDone", 32'(DbgRspValid), 32'h0);

        // 3: continuous contention, debug forced in on the fifth cycle
        cyc();
        CpuReq = 1'b1; CpuWrite = 1'b0; CpuAddr = 32'h100;
        DbgValid = 1'b1; DbgAddr = 32'h100;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("t3_DbgReady", 32'(DbgReady), 32'(i == 4));
            chk("t3_CpuStall", 32'(CpuStall), 32'(i == 4));
            cyc();
            if (i == 4) DbgValid = 1'b0;
        end
        drain();
        CpuReq = 1'b0;

        // 4: debug write, CPU runs free during the response
        DbgValid = 1'b1; DbgWrite = 1'b1; DbgAddr = 32'h200; DbgWD = 32'h12345678;
        @(negedge CLK);
        chk("t4_DbgReady", 32'(DbgReady), 32'h1);
        chk("t4_MemWrite", 32'(MemWrite), 32'h1);
        cyc();
        DbgValid = 1'b0; DbgWrite = 1'b0;
        CpuReq = 1'b1; CpuAddr = 32'h200;
        @(negedge CLK);
        chk("t4_CpuStall", 32'(CpuStall), 32'h0);
        chk("t4_RspData", DbgRspData, 32'h0);
        chk("t4_CpuRD", CpuRD, 32'h12345678);
        cyc();
        drain();
        CpuReq = 1'b0;

        // 5: reset while a response is pending
        DbgValid = 1'b1; DbgAddr = 32'h200;
        cyc();
        DbgValid = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("t5_RspValidAsync", 32'(DbgRspValid), 32'h0);
        cyc();
        RST_N = 1'b1;
        @(negedge CLK);
        chk("t5_NoStale", 32'(DbgRspValid), 32'h0);
        cyc();
        CpuReq = 1'b1; DbgValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t5_DbgReady", 32'(DbgReady), 32'(i == 4));
            cyc();
            if (i == 4) DbgValid = 1'b0;
        end
        drain();

        // 6: dropping the request restarts the wait count
        DbgValid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("t6_pre", 32'(DbgReady), 32'h0);
            cyc();
        end
        DbgValid = 1'b0;
        cyc();
        DbgValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("t6_DbgReady", 32'(DbgReady), 32'(i == 4));
            cyc();
            if (i == 4) DbgValid = 1'b0;
        end
        drain();
        CpuReq = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
